// File: rtl/ring_rx_pkg.sv
// ---------------------------------------------------------------------------
// ring_rx_pkg
// Shared constants, state encoding and helpers for the ring pattern receiver.
//   RX_WIDTH      : serial word length in bits
//   RX_ERR_MAX    : saturation value of the mismatch counter
//   RX_LOSS_WORDS : consecutive mismatched words that drop lock
// Configuration macro used by the receiver: RING_RX_ERRCNT_EN
// ---------------------------------------------------------------------------
package ring_rx_pkg;

    localparam int RX_WIDTH      = 5;
    localparam int RX_ERR_MAX    = 255;
    localparam int RX_LOSS_WORDS = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

    // Saturating 8-bit increment: holds once value reaches limit.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value,
                                            input logic [7:0] limit);
        logic [7:0] result;
        if (value >= limit) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ring_rx_mod_counter.sv
// ---------------------------------------------------------------------------
// ring_rx_mod_counter
// Modulo-N up counter with count enable and asynchronous clear. Counts
// 0..N-1 and wraps; tc is high while the count sits at N-1, so the caller
// sees the terminal count on the same cycle that the wrap is enabled.
// Ports:
//   clk   in  1  rising-edge clock
//   clear in  1  asynchronous active-high clear (count -> 0)
//   en    in  1  advance the count this cycle
//   tc    out 1  count == N-1 (decoded from the count register)
// ---------------------------------------------------------------------------
module ring_rx_mod_counter #(
    parameter int N = 5
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    assign tc = (count_r == LAST);

    // Next count: wrap at terminal count, hold when not enabled.
    always_comb begin
        count_next_s = count_r;
        if (en) begin
            if (tc) begin
                count_next_s = {W{1'b0}};
            end else begin
                count_next_s = count_r + W'(1'b1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/ring_pattern_receiver.sv
// ---------------------------------------------------------------------------
// ring_pattern_receiver
// Serial receiver for the circular shift register link. Samples serialIn
// (MSB of each word first) on every enabled clockpulse, slides a WIDTH-bit
// window until it equals reference (HUNT), then frames words every WIDTH
// enabled cycles (LOCKED), publishing each one on word/wordValid.
//
// Optional feature (macro RING_RX_ERRCNT_EN):
//   defined     : errorCount counts mismatched words while locked
//                 (saturating at ERR_MAX); LOSS_WORDS consecutive
//                 mismatches drop back to HUNT.
//   not defined : errorCount is 8'd0, no counter flops, LOCKED only
//                 leaves through clear.
//
// Ports:
//   clockpulse in  1      rising-edge clock
//   clear      in  1      asynchronous active-high reset
//   enable     in  1      sample serialIn this cycle; low holds all state
//   serialIn   in  1      serial bit stream, MSB first
//   reference  in  WIDTH  expected word, sampled at each compare
//   word       out WIDTH  last assembled word (registered)
//   wordValid  out 1      one-cycle pulse when word updates
//   locked     out 1      receiver is in LOCKED
//   errorCount out 8      mismatched words while locked (saturating)
// ---------------------------------------------------------------------------
module ring_pattern_receiver
    import ring_rx_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH
`ifdef RING_RX_ERRCNT_EN
    ,
    parameter int ERR_MAX    = RX_ERR_MAX,
    parameter int LOSS_WORDS = RX_LOSS_WORDS
`endif
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             enable,
    input  logic             serialIn,
    input  logic [WIDTH-1:0] reference,
    output logic [WIDTH-1:0] word,
    output logic             wordValid,
    output logic             locked,
    output logic [7:0]       errorCount
);

    localparam int                FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

    // Only the WIDTH-1 most recent bits are stored; the live serialIn bit
    // completes the window, so a compare sees the bit being sampled now.
    logic [WIDTH-2:0] hist_r;
    logic [WIDTH-1:0] window_s;
    logic             match_s;

    rx_state_e        state_r;
    rx_state_e        state_next_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_next_s;
    logic [WIDTH-1:0] word_r;
    logic [WIDTH-1:0] word_next_s;
    logic             valid_r;
    logic             valid_next_s;
    logic             bit_en_s;
    logic             bit_tc_s;

`ifdef RING_RX_ERRCNT_EN
    localparam int MISS_W = $clog2(LOSS_WORDS + 1);

    logic [MISS_W-1:0] miss_r;
    logic [MISS_W-1:0] miss_next_s;
    logic [7:0]        err_r;
    logic [7:0]        err_next_s;
`endif

    assign window_s = {hist_r, serialIn};
    assign match_s  = (window_s == reference);

    // The bit counter only runs while locked. Lock is entered with it at
    // zero and only lost on its wrap, so it is always zero during HUNT.
    assign bit_en_s = enable && (state_r == LOCKED);

    ring_rx_mod_counter #(
        .N (WIDTH)
    ) u_bit_count (
        .clk   (clockpulse),
        .clear (clear),
        .en    (bit_en_s),
        .tc    (bit_tc_s)
    );

    // Serial history register: shifts one bit per enabled cycle.
    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            hist_r <= {(WIDTH-1){1'b0}};
        end else if (enable) begin
            hist_r <= window_s[WIDTH-2:0];
        end else begin
            hist_r <= hist_r;
        end
    end

    // Hunt/lock next-state and registered-output next values.
    always_comb begin
        state_next_s = state_r;
        fill_next_s  = fill_r;
        word_next_s  = word_r;
        valid_next_s = 1'b0;
`ifdef RING_RX_ERRCNT_EN
        miss_next_s  = miss_r;
        err_next_s   = err_r;
`endif
        case (state_r)
            HUNT: begin
                if (enable) begin
                    if (fill_r == FILL_MAX) begin
                        // Window is full: slide one bit per cycle until it matches.
                        if (match_s) begin
                            state_next_s = LOCKED;
                            word_next_s  = window_s;
                            valid_next_s = 1'b1;
`ifdef RING_RX_ERRCNT_EN
                            miss_next_s  = {MISS_W{1'b0}};
`endif
                        end else begin
                            state_next_s = HUNT;
                        end
                    end else begin
                        fill_next_s = fill_r + FILL_W'(1'b1);
                    end
                end else begin
                    state_next_s = HUNT;
                end
            end
            LOCKED: begin
                if (enable && bit_tc_s) begin
                    word_next_s  = window_s;
                    valid_next_s = 1'b1;
`ifdef RING_RX_ERRCNT_EN
                    if (match_s) begin
                        miss_next_s = {MISS_W{1'b0}};
                    end else begin
                        err_next_s = sat_inc8(err_r, 8'(ERR_MAX));
                        if ((int'(miss_r) + 32'sd1) >= LOSS_WORDS) begin
                            // Lock lost on this compare; errorCount is kept.
                            state_next_s = HUNT;
                            fill_next_s  = {FILL_W{1'b0}};
                            miss_next_s  = {MISS_W{1'b0}};
                        end else begin
                            miss_next_s = miss_r + MISS_W'(1'b1);
                        end
                    end
`endif
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s = HUNT;
            end
        endcase
    end

    // State, fill count and word output registers.
    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state_r <= HUNT;
            fill_r  <= {FILL_W{1'b0}};
            word_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fill_r  <= fill_next_s;
            word_r  <= word_next_s;
            valid_r <= valid_next_s;
        end
    end

`ifdef RING_RX_ERRCNT_EN
    // Mismatch tracking registers.
    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            miss_r <= {MISS_W{1'b0}};
            err_r  <= 8'd0;
        end else begin
            miss_r <= miss_next_s;
            err_r  <= err_next_s;
        end
    end

    assign errorCount = err_r;
`else
    assign errorCount = 8'd0;
`endif

    assign word      = word_r;
    assign wordValid = valid_r;
    assign locked    = (state_r == LOCKED);

endmodule
